// File: rtl/sort_input_loader_pkg.sv
// Shared types and defaults for the sorter input loader.
// The state encoding is kept here so the top and any future status logic agree on it.
package sort_input_loader_pkg;

  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    ENTER = 2'd0,
    REQ   = 2'd1,
    RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/sort_input_loader_btn_debounce.sv
// Two-flop synchronizer plus counter debouncer for a raw push button.
// Emits the clean level and a one-cycle pulse on its rising edge.
module btn_debounce #(
  parameter int DB_LIMIT = 1000000,
  parameter int DB_W     = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic            press_q;
  logic [DB_W-1:0] cnt_q;

  // The counter only runs while the synchronized input disagrees with the
  // debounced level, so any bounce back to the old level restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_W'(DB_LIMIT - 1)) begin
        level_q <= ~level_q;
        press_q <= ~level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + DB_W'(1);
      end
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/sort_input_loader.sv
// Front end for the 4-entry bubble sorter: captures four debounced switch
// entries, then handshakes a start request with the slow-clock sorter.
module sort_input_loader
  import sort_input_loader_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DB_LIMIT = 1000000,
  parameter int DB_W     = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_raw,
  input  logic              sorter_idle,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [DATA_W-1:0] c_out,
  output logic [DATA_W-1:0] d_out,
  output logic              start,
  output logic [1:0]        slot,
  output logic              entry_en
);

  logic              btnLevel;
  logic              btnPress;
  logic              idleSync1_q;
  logic              idleS_q;
  state_e            state_q;
  logic [1:0]        slot_q;
  logic              start_q;
  logic              entryEn_q;
  logic [DATA_W-1:0] regs_q [4];

  btn_debounce #(
    .DB_LIMIT(DB_LIMIT),
    .DB_W    (DB_W)
  ) u_db (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_raw),
    .level  (btnLevel),
    .press  (btnPress)
  );

  // Outputs are updated together with the state so they stay glitch-free Moore signals.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idleSync1_q <= 1'b0;
      idleS_q     <= 1'b0;
      state_q     <= ENTER;
      slot_q      <= 2'd0;
      start_q     <= 1'b0;
      entryEn_q   <= 1'b1;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      idleSync1_q <= sorter_idle;
      idleS_q     <= idleSync1_q;
      case (state_q)
        ENTER: begin
          if (btnPress && btnLevel) begin
            regs_q[slot_q] <= sw;
            if (slot_q == 2'd3) begin
              slot_q    <= 2'd0;
              state_q   <= REQ;
              start_q   <= 1'b1;
              entryEn_q <= 1'b0;
            end else begin
              slot_q <= slot_q + 2'd1;
            end
          end
        end
        REQ: begin
          // The sorter dropping idle proves it has seen start for a full slow period.
          if (!idleS_q) begin
            state_q <= RUN;
            start_q <= 1'b0;
          end
        end
        RUN: begin
          if (idleS_q) begin
            state_q   <= ENTER;
            entryEn_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ENTER;
          start_q   <= 1'b0;
          entryEn_q <= 1'b1;
        end
      endcase
    end
  end

  assign a_out    = regs_q[0];
  assign b_out    = regs_q[1];
  assign c_out    = regs_q[2];
  assign d_out    = regs_q[3];
  assign start    = start_q;
  assign slot     = slot_q;
  assign entry_en = entryEn_q;

endmodule

// File: tb/tb_sort_input_loader.sv
// Directed bench for sort_input_loader with a short debounce window.
// Expected values are hand-computed from the entry/handshake sequence.
module tb_sort_input_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       btn_raw;
  logic       sorter_idle;
  logic [3:0] a_out, b_out, c_out, d_out;
  logic       start;
  logic [1:0] slot;
  logic       entry_en;

  int checkCount = 0;
  int passCount  = 0;

  sort_input_loader #(
    .DATA_W  (4),
    .DB_LIMIT(4),
    .DB_W    (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw         (sw),
    .btn_raw    (btn_raw),
    .sorter_idle(sorter_idle),
    .a_out      (a_out),
    .b_out      (b_out),
    .c_out      (c_out),
    .d_out      (d_out),
    .start      (start),
    .slot       (slot),
    .entry_en   (entry_en)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
  endtask

  // Clean press: hold high for highCycles, then release long enough to debounce.
  task automatic applyStimulus(input logic [3:0] value, input int highCycles);
    sw      = value;
    btn_raw = 1'b1;
    tick(highCycles);
    btn_raw = 1'b0;
    tick(20);
  endtask

  initial begin
    logic startDropped;
    reset       = 1'b1;
    sw          = 4'h0;
    btn_raw     = 1'b0;
    sorter_idle = 1'b1;
    tick(2);
    checkOutput("rst_a", a_out, 0);
    checkOutput("rst_d", d_out, 0);
    checkOutput("rst_start", start, 0);
    checkOutput("rst_slot", slot, 0);
    checkOutput("rst_entry_en", entry_en, 1);
    reset = 1'b0;
    tick(1);

    applyStimulus(4'h9, 20);
    checkOutput("slot_after_a", slot, 1);
    applyStimulus(4'h2, 20);
    checkOutput("slot_after_b", slot, 2);
    applyStimulus(4'h7, 20);
    checkOutput("slot_after_c", slot, 3);

    // 4th press timed exactly: 2 sync + 4 debounce edges to press, capture on the 7th.
    sw      = 4'h4;
    btn_raw = 1'b1;
    tick(6);
    checkOutput("d_before_capture", d_out, 0);
    tick(1);
    checkOutput("d_capture", d_out, 4);
    checkOutput("slot_wrap", slot, 0);
    tick(1);
    checkOutput("start_after_d", start, 1);
    checkOutput("entry_en_req", entry_en, 0);
    tick(12);
    btn_raw = 1'b0;
    tick(20);
    checkOutput("a_val", a_out, 9);
    checkOutput("b_val", b_out, 2);
    checkOutput("c_val", c_out, 7);

    // REQ with sorter still idle for 50 cycles, pressing F meanwhile.
    startDropped = 1'b0;
    for (int i = 0; i < 50; i++) begin
      sw      = 4'hF;
      btn_raw = (i < 20);
      tick(1);
      if (start !== 1'b1) startDropped = 1'b1;
    end
    checkOutput("start_held_50", startDropped, 0);
    sorter_idle = 1'b0;
    tick(2);
    checkOutput("start_before_fall", start, 1);
    tick(1);
    checkOutput("start_fall", start, 0);
    checkOutput("entry_en_run", entry_en, 0);

    applyStimulus(4'hF, 20);
    checkOutput("busy_a", a_out, 9);
    checkOutput("busy_b", b_out, 2);
    checkOutput("busy_c", c_out, 7);
    checkOutput("busy_d", d_out, 4);
    checkOutput("busy_slot", slot, 0);

    sorter_idle = 1'b1;
    tick(2);
    checkOutput("entry_en_before", entry_en, 0);
    tick(1);
    checkOutput("entry_en_back", entry_en, 1);

    // Bouncing button: short pulses then a stable high.
    sw = 4'h3;
    for (int i = 0; i < 12; i++) begin
      btn_raw = ((i / 2) % 2 == 0);
      tick(1);
    end
    checkOutput("bounce_no_press", slot, 0);
    btn_raw = 1'b1;
    tick(10);
    btn_raw = 1'b0;
    tick(20);
    checkOutput("bounce_slot", slot, 1);
    checkOutput("bounce_a", a_out, 3);

    applyStimulus(4'h1, 20);
    applyStimulus(4'h1, 20);
    applyStimulus(4'h1, 20);
    checkOutput("req_again_start", start, 1);

    // Asynchronous reset mid-REQ.
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_start", start, 0);
    checkOutput("mid_rst_a", a_out, 0);
    checkOutput("mid_rst_d", d_out, 0);
    checkOutput("mid_rst_slot", slot, 0);
    checkOutput("mid_rst_entry_en", entry_en, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(1);
    applyStimulus(4'h5, 20);
    checkOutput("post_rst_a", a_out, 5);
    checkOutput("post_rst_slot", slot, 1);

    // Held button yields one capture only.
    applyStimulus(4'h6, 200);
    checkOutput("held_slot", slot, 2);
    checkOutput("held_b", b_out, 6);
    checkOutput("held_c", c_out, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
